// File: rtl/sc_pkg.sv
// Shared constants, FSM state type and RNG step function for the stochastic
// number generator blocks.
package sc_pkg;

    localparam int unsigned SC_WIDTH   = 8;
    localparam logic [7:0]  SEED_X_DEF = 8'h01;
    localparam logic [7:0]  SEED_Y_DEF = 8'hA5;
    // Taps r[7], r[5], r[4], r[3]: x^8+x^6+x^5+x^4+1
    localparam logic [7:0]  TAP_MASK   = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_e;

    // LFSR step with the all-zero state spliced in, giving a full 256-state period.
    function automatic logic [7:0] rng_next(input logic [7:0] r);
        logic fb;
        fb = (^(r & TAP_MASK)) ^ (r[6:0] == 7'd0);
        return {r[6:0], fb};
    endfunction

endpackage

// File: rtl/sc_pair_sng_if.sv
// Request/stream bundle between the stream-pair generator and its user.
interface sc_pair_sng_if
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = SC_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] py;
    logic             corr;
    logic             busy;
    logic             bs_valid;
    logic             x;
    logic             y;
    logic             done;

    modport master (
        output start, px, py, corr,
        input  busy, bs_valid, x, y, done
    );

    modport slave (
        input  start, px, py, corr,
        output busy, bs_valid, x, y, done
    );
endinterface

// File: rtl/sc_debruijn_rng.sv
// 8-bit de Bruijn sequence generator; load restarts from SEED, en steps once.
module sc_debruijn_rng
    import sc_pkg::*;
#(
    parameter logic [7:0] SEED = SEED_X_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    output logic [7:0] r
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= SEED;
        end else if (load) begin
            r <= SEED;
        end else if (en) begin
            r <= rng_next(r);
        end
    end

endmodule

// File: rtl/sc_pair_sng.sv
// Dual stochastic number generator: turns px/py into a pair of 2^WIDTH-bit
// serial bitstreams, either sharing one RNG (correlated) or using two.
module sc_pair_sng
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH  = SC_WIDTH,
    parameter logic [7:0]  SEED_X = SEED_X_DEF,
    parameter logic [7:0]  SEED_Y = SEED_Y_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    sc_pair_sng_if.slave bus
);

    localparam int unsigned     CNT_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] N    = {1'b1, {WIDTH{1'b0}}};

    sc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] px_q, py_q;
    logic             corr_q;
    logic             valid_q, valid_d;
    logic             x_q, x_d;
    logic             y_q, y_d;
    logic             done_q, done_d;
    logic             accept_c;
    logic             adv_c;
    logic [7:0]       rng_x;
    logic [7:0]       rng_y;
    logic [7:0]       rng_y_sel;

    sc_debruijn_rng #(.SEED(SEED_X)) u_rng_x (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_c),
        .en    (adv_c),
        .r     (rng_x)
    );

    sc_debruijn_rng #(.SEED(SEED_Y)) u_rng_y (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_c),
        .en    (adv_c),
        .r     (rng_y)
    );

    assign rng_y_sel = corr_q ? rng_x : rng_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RNG control and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        adv_c    = 1'b0;
        valid_d  = 1'b0;
        x_d      = 1'b0;
        y_d      = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                x_d     = (WIDTH'(rng_x) < px_q);
                y_d     = (WIDTH'(rng_y_sel) < py_q);
                adv_c   = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_d == N) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers; inputs are captured only on the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            px_q    <= '0;
            py_q    <= '0;
            corr_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            if (accept_c) begin
                px_q   <= bus.px;
                py_q   <= bus.py;
                corr_q <= bus.corr;
            end
        end
    end

    assign bus.busy     = valid_q;
    assign bus.bs_valid = valid_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sc_pair_sng.sv
// Directed bench for sc_pair_sng: stream counts, correlation relations,
// start/reset corner cases and a standalone RNG period check.
module tb_sc_pair_sng;
    import sc_pkg::*;

    localparam int N        = 256;
    localparam int REL_NONE = 0;
    localparam int REL_NEST = 1;
    localparam int REL_EQ   = 2;
    localparam int REL_DIFF = 3;

    typedef struct {
        logic [7:0] px;
        logic [7:0] py;
        logic       corr;
        int         cx;
        int         cy;
        int         rel;
        string      nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rng_load;
    logic       rng_en;
    logic [7:0] rng_r;

    logic x_bits [N];
    logic y_bits [N];
    logic ref_x  [N];
    logic ref_y  [N];

    int checks   = 0;
    int failures = 0;

    sc_pair_sng_if #(.WIDTH(8)) bus ();

    sc_pair_sng #(.WIDTH(8), .SEED_X(8'h01), .SEED_Y(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sc_debruijn_rng #(.SEED(8'h00)) u_rng (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rng_load),
        .en    (rng_en),
        .r     (rng_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.busy, bus.bs_valid, bus.x, bus.y, bus.done});
    endfunction

    // One stream pair. glitch_at>=0 pulses start (and scrambles px/corr) after
    // that bit and again during DONE; rst_at>=0 resets after that bit;
    // chain leaves start high into the next run, which uses pre_started.
    task automatic run_stream(input logic [7:0] px, input logic [7:0] py,
                              input logic corr, input bit pre_started,
                              input int glitch_at, input int rst_at,
                              input bit chain, input string nm);
        int nvalid;
        nvalid = 0;
        if (!pre_started) begin
            @(negedge clk);
            bus.px    = px;
            bus.py    = py;
            bus.corr  = corr;
            bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, "_accept_quiet"}, int'({bus.done, bus.bs_valid}), 0);
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            if (bus.bs_valid && bus.busy) nvalid++;
            x_bits[k] = bus.x;
            y_bits[k] = bus.y;
            bus.start = (k == glitch_at) || (glitch_at >= 0 && k == N - 1);
            if (k == glitch_at) begin
                bus.px   = ~px;
                bus.corr = ~corr;
            end
            if (k == rst_at) begin
                int late;
                rst_n     = 1'b0;
                bus.start = 1'b1;
                @(posedge clk); #1;
                rst_n     = 1'b1;
                bus.start = 1'b0;
                chk({nm, "_rst_outs"}, outs(), 0);
                late = 0;
                repeat (4) begin
                    @(posedge clk); #1;
                    if (bus.done || bus.bs_valid) late++;
                end
                chk({nm, "_rst_no_done"}, late, 0);
                return;
            end
        end
        @(posedge clk); #1;
        bus.start = chain;
        chk({nm, "_nvalid"}, nvalid, N);
        chk({nm, "_done_pulse"}, outs(), 1);
        if (!chain) begin
            @(posedge clk); #1;
            chk({nm, "_done_clear"}, outs(), 0);
            @(posedge clk); #1;
            chk({nm, "_no_requeue"}, outs(), 0);
        end
    endtask

    task automatic check_stream(input string nm, input int cx, input int cy, input int rel);
        int pcx, pcy, nest_bad, diff;
        pcx = 0; pcy = 0; nest_bad = 0; diff = 0;
        for (int k = 0; k < N; k++) begin
            pcx += int'(x_bits[k]);
            pcy += int'(y_bits[k]);
            if (y_bits[k] && !x_bits[k]) nest_bad++;
            if (x_bits[k] != y_bits[k]) diff++;
        end
        chk({nm, "_popx"}, pcx, cx);
        chk({nm, "_popy"}, pcy, cy);
        case (rel)
            REL_NEST: chk({nm, "_nested"}, nest_bad, 0);
            REL_EQ:   chk({nm, "_equal"}, diff, 0);
            REL_DIFF: chk({nm, "_differ"}, int'(diff > 0), 1);
            default:  ;
        endcase
    endtask

    task automatic rng_test();
        int seen [256];
        int distinct;
        foreach (seen[i]) seen[i] = 0;
        @(negedge clk);
        rng_load = 1'b1;
        @(posedge clk); #1;
        rng_load = 1'b0;
        rng_en   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            seen[rng_r]++;
            @(posedge clk); #1;
        end
        rng_en   = 1'b0;
        distinct = 0;
        foreach (seen[i]) if (seen[i] == 1) distinct++;
        chk("rng_all_values_once", distinct, 256);
        chk("rng_back_to_seed", int'(rng_r), 0);
        @(posedge clk); #1;
        chk("rng_hold_no_en", int'(rng_r), 0);
    endtask

    initial begin
        vec_t vecs [6];
        int   mism;

        vecs[0] = '{8'h80, 8'h40, 1'b1, 128,  64, REL_NEST, "v80_40_c1"};
        vecs[1] = '{8'h80, 8'h80, 1'b0, 128, 128, REL_DIFF, "v80_80_c0"};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 128, 128, REL_EQ,   "v80_80_c1"};
        vecs[3] = '{8'h00, 8'hFF, 1'b0,   0, 255, REL_NONE, "v00_FF_c0"};
        vecs[4] = '{8'hFF, 8'h00, 1'b1, 255,   0, REL_NEST, "vFF_00_c1"};
        vecs[5] = '{8'h37, 8'hA2, 1'b0,  55, 162, REL_NONE, "v37_A2_c0"};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.px    = '0;
        bus.py    = '0;
        bus.corr  = 1'b0;
        rng_load  = 1'b0;
        rng_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", outs(), 0);

        foreach (vecs[i]) begin
            run_stream(vecs[i].px, vecs[i].py, vecs[i].corr, 1'b0, -1, -1, 1'b0, vecs[i].nm);
            check_stream(vecs[i].nm, vecs[i].cx, vecs[i].cy, vecs[i].rel);
        end
        for (int k = 0; k < N; k++) begin
            ref_x[k] = x_bits[k];
            ref_y[k] = y_bits[k];
        end

        rng_test();

        // start mid-run and in DONE, px/corr changed mid-run
        run_stream(8'h80, 8'h40, 1'b1, 1'b0, 10, -1, 1'b0, "glitch");
        check_stream("glitch", 128, 64, REL_NEST);

        // reset mid-run, then restart with the reference inputs
        run_stream(8'h37, 8'hA2, 1'b0, 1'b0, -1, 100, 1'b0, "abort");
        mism = 0;
        for (int k = 0; k <= 100; k++)
            if (x_bits[k] != ref_x[k] || y_bits[k] != ref_y[k]) mism++;
        chk("abort_prefix_match", mism, 0);
        run_stream(8'h37, 8'hA2, 1'b0, 1'b0, -1, -1, 1'b0, "restart");
        mism = 0;
        for (int k = 0; k < N; k++)
            if (x_bits[k] != ref_x[k] || y_bits[k] != ref_y[k]) mism++;
        chk("restart_match", mism, 0);

        // back-to-back runs: second start sampled at T+N+2
        run_stream(8'h80, 8'h40, 1'b1, 1'b0, -1, -1, 1'b1, "b2b_first");
        check_stream("b2b_first", 128, 64, REL_NEST);
        run_stream(8'h80, 8'h40, 1'b1, 1'b1, -1, -1, 1'b0, "b2b_second");
        check_stream("b2b_second", 128, 64, REL_NEST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
